// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i memory-side blocks: arbiter states, request
// sources and memory port widths.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } arb_src_t;

    localparam int MEM_AW = 32;
    localparam int MEM_DW = 32;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Counts BUSY cycles without a memory ack; expired flags the cycle whose
// increment would bring the count to TIMEOUT.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(TIMEOUT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between instruction fetch and load/store,
// with a bounded load/store streak and a per-transaction timeout.
module mem_port_arbiter
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT       = 255,
    parameter int MAX_LS_STREAK = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [MEM_AW-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic              o_if_err,
    output logic [MEM_DW-1:0] o_if_rdata,
    input  logic              i_ls_req,
    input  logic [MEM_AW-1:0] i_ls_addr,
    input  logic              i_ls_wren,
    input  logic [MEM_DW-1:0] i_ls_wdata,
    input  logic [3:0]        i_ls_bmask,
    output logic              o_ls_ack,
    output logic              o_ls_err,
    output logic [MEM_DW-1:0] o_ls_rdata,
    output logic              o_mem_req,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic              o_mem_wren,
    output logic [MEM_DW-1:0] o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic              i_mem_ack,
    input  logic [MEM_DW-1:0] i_mem_rdata,
    output logic              o_busy,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a requester holds req and payload stable until it sees its
    // one-cycle ack; ack/err/rdata are meaningful only while ack is high.

    localparam int SW = $clog2(MAX_LS_STREAK + 1);

    arb_state_t        state_q, state_d;
    arb_src_t          src_q, src_d;
    logic [SW-1:0]     streak_q, streak_d;
    logic              mem_req_q, mem_req_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wren_q, mem_wren_d;
    logic [MEM_DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_bmask_q, mem_bmask_d;
    logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic [MEM_DW-1:0] if_rdata_q, if_rdata_d;
    logic              ls_ack_q, ls_ack_d, ls_err_q, ls_err_d;
    logic [MEM_DW-1:0] ls_rdata_q, ls_rdata_d;
    logic              grant;
    logic              timer_en;
    logic              expired;
    logic [MEM_DW-1:0] rsp_data;

    assign timer_en = (state_q == BUSY) && !i_mem_ack;

    arb_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clr     (grant),
        .en      (timer_en),
        .expired (expired)
    );

    // A timed-out access or a write returns zero data.
    assign rsp_data = (i_mem_ack && !mem_wren_q) ? i_mem_rdata : '0;

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wren_d  = mem_wren_q;
        mem_wdata_d = mem_wdata_q;
        mem_bmask_d = mem_bmask_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        if_rdata_d  = '0;
        ls_ack_d    = 1'b0;
        ls_err_d    = 1'b0;
        ls_rdata_d  = '0;
        grant       = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_ls_req && (!i_if_req || (streak_q != SW'(MAX_LS_STREAK)))) begin
                    grant       = 1'b1;
                    src_d       = SRC_LS;
                    mem_addr_d  = i_ls_addr;
                    mem_wren_d  = i_ls_wren;
                    mem_wdata_d = i_ls_wdata;
                    mem_bmask_d = i_ls_bmask;
                    // Winning over a waiting fetch can only happen below the cap.
                    streak_d    = i_if_req ? streak_q + SW'(1) : '0;
                end else if (i_if_req) begin
                    grant       = 1'b1;
                    src_d       = SRC_IF;
                    mem_addr_d  = i_if_addr;
                    mem_wren_d  = 1'b0;
                    mem_wdata_d = '0;
                    mem_bmask_d = 4'hF;
                    streak_d    = '0;
                end
                if (grant) begin
                    mem_req_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (i_mem_ack || expired) begin
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                    if (src_q == SRC_LS) begin
                        ls_ack_d   = 1'b1;
                        ls_err_d   = !i_mem_ack;
                        ls_rdata_d = rsp_data;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_err_d   = !i_mem_ack;
                        if_rdata_d = rsp_data;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            src_q       <= SRC_IF;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wren_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_bmask_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_ack_q    <= 1'b0;
            ls_err_q    <= 1'b0;
            ls_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wren_q  <= mem_wren_d;
            mem_wdata_q <= mem_wdata_d;
            mem_bmask_q <= mem_bmask_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            if_rdata_q  <= if_rdata_d;
            ls_ack_q    <= ls_ack_d;
            ls_err_q    <= ls_err_d;
            ls_rdata_q  <= ls_rdata_d;
        end
    end

    assign o_if_ack    = if_ack_q;
    assign o_if_err    = if_err_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_ack    = ls_ack_q;
    assign o_ls_err    = ls_err_q;
    assign o_ls_rdata  = ls_rdata_q;
    assign o_mem_req   = mem_req_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wren  = mem_wren_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_bmask = mem_bmask_q;
    assign o_busy      = (state_q != IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed and randomized transactions checked
// against a transaction-level model of arbitration, memory contents and timeout.
module tb_mem_port_arbiter;
    import rv32i_pkg::*;

    localparam int TO   = 4;
    localparam int MAXS = 2;

    logic        clk;
    logic        i_rst_n;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_ack, o_if_err;
    logic [31:0] o_if_rdata;
    logic        i_ls_req;
    logic [31:0] i_ls_addr;
    logic        i_ls_wren;
    logic [31:0] i_ls_wdata;
    logic [3:0]  i_ls_bmask;
    logic        o_ls_ack, o_ls_err;
    logic [31:0] o_ls_rdata;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_wren;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_busy;
    logic [1:0]  o_dbg_state;

    mem_port_arbiter #(.TIMEOUT(TO), .MAX_LS_STREAK(MAXS)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_ack    (o_if_ack),
        .o_if_err    (o_if_err),
        .o_if_rdata  (o_if_rdata),
        .i_ls_req    (i_ls_req),
        .i_ls_addr   (i_ls_addr),
        .i_ls_wren   (i_ls_wren),
        .i_ls_wdata  (i_ls_wdata),
        .i_ls_bmask  (i_ls_bmask),
        .o_ls_ack    (o_ls_ack),
        .o_ls_err    (o_ls_err),
        .o_ls_rdata  (o_ls_rdata),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wren  (o_mem_wren),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_bmask (o_mem_bmask),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .o_busy      (o_busy),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          n_tests = 0;
    int          n_fail  = 0;
    logic        if_pend = 1'b0;
    logic        ls_pend = 1'b0;
    int          streak  = 0;
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // driver tasks
    task automatic new_if(input logic [31:0] a);
        i_if_req  = 1'b1;
        i_if_addr = a;
        if_pend   = 1'b1;
    endtask

    task automatic new_ls(input logic [31:0] a, input logic w, input logic [31:0] wd,
                          input logic [3:0] bm);
        i_ls_req   = 1'b1;
        i_ls_addr  = a;
        i_ls_wren  = w;
        i_ls_wdata = wd;
        i_ls_bmask = bm;
        ls_pend    = 1'b1;
    endtask

    task automatic rand_if();
        new_if(32'h1000 + 32'($urandom_range(0, 7)) * 4);
    endtask

    task automatic rand_ls();
        new_ls(32'h1000 + 32'($urandom_range(0, 7)) * 4, 1'($urandom_range(0, 1)),
               $urandom, 4'($urandom_range(1, 15)));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_mem_req"}, o_mem_req, 0);
        check({tag, "_acks"}, {o_if_ack, o_ls_ack}, 0);
        check({tag, "_state"}, o_dbg_state, IDLE);
    endtask

    // One full transaction from the IDLE cycle; the memory acks on BUSY edge d,
    // or never if d > TO. obs reports which requester actually got the ack.
    task automatic run_txn(input int d, output logic obs);
        logic        ls_win, ew, tmo;
        logic [31:0] ea, ewd, exp_rd, w;
        logic [3:0]  ebm;
        int          last;
        ls_win = ls_pend && (!if_pend || streak != MAXS);
        if (ls_win) begin
            ea = i_ls_addr; ew = i_ls_wren; ewd = i_ls_wdata; ebm = i_ls_bmask;
            streak = if_pend ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
        end else begin
            ea = i_if_addr; ew = 1'b0; ewd = '0; ebm = 4'hF;
            streak = 0;
        end
        tmo  = (d > TO);
        last = tmo ? TO : d;
        tick();
        check("grant_mem_req", o_mem_req, 1);
        check("grant_busy", o_busy, 1);
        check("grant_addr", o_mem_addr, ea);
        check("grant_wren", o_mem_wren, ew);
        check("grant_bmask", o_mem_bmask, ebm);
        if (ls_win) check("grant_wdata", o_mem_wdata, ewd);
        for (int k = 1; k <= last; k++) begin
            i_mem_ack   = (k == d);
            i_mem_rdata = (k == d && !ew) ? mem_rd(ea) : $urandom;
            tick();
            if (k < last) begin
                check("hold_mem_req", o_mem_req, 1);
                check("hold_addr", o_mem_addr, ea);
                check("hold_acks", {o_if_ack, o_ls_ack}, 0);
            end
        end
        exp_rd = (tmo || ew) ? 32'h0 : mem_rd(ea);
        if (!tmo && ew) begin
            w = mem_rd(ea);
            for (int b = 0; b < 4; b++) if (ebm[b]) w[8*b +: 8] = ewd[8*b +: 8];
            mem[ea] = w;
        end
        check("rsp_mem_req", o_mem_req, 0);
        check("rsp_if_ack", o_if_ack, !ls_win);
        check("rsp_if_err", o_if_err, !ls_win && tmo);
        check("rsp_if_rdata", o_if_rdata, ls_win ? 32'h0 : exp_rd);
        check("rsp_ls_ack", o_ls_ack, ls_win);
        check("rsp_ls_err", o_ls_err, ls_win && tmo);
        check("rsp_ls_rdata", o_ls_rdata, ls_win ? exp_rd : 32'h0);
        obs = o_ls_ack;
        if (ls_win) begin ls_pend = 1'b0; i_ls_req = 1'b0; end
        else begin if_pend = 1'b0; i_if_req = 1'b0; end
        i_mem_ack   = 1'($urandom_range(0, 1));
        i_mem_rdata = $urandom;
        tick();
        check_idle("after_rsp");
    endtask

    task automatic drain();
        logic obs;
        while (if_pend || ls_pend) run_txn(1, obs);
    endtask

    task automatic grant_order(input int n);
        logic obs;
        for (int i = 0; i < n; i++) begin
            if (!if_pend) rand_if();
            if (!ls_pend) rand_ls();
            run_txn($urandom_range(1, 3), obs);
            check("grant_order", obs, exp_q.pop_front());
        end
    endtask

    initial begin
        logic obs;
        i_rst_n = 1'b0; i_if_req = 1'b0; i_if_addr = '0;
        i_ls_req = 1'b0; i_ls_addr = '0; i_ls_wren = 1'b0; i_ls_wdata = '0; i_ls_bmask = '0;
        i_mem_ack = 1'b0; i_mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {o_if_ack, o_if_err, o_ls_ack, o_ls_err, o_mem_req, o_mem_wren, o_busy}, 0);
        check("rst_if_rdata", o_if_rdata, 0);
        check("rst_ls_rdata", o_ls_rdata, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_wdata", o_mem_wdata, 0);
        check("rst_mem_bmask", o_mem_bmask, 0);
        check("rst_state", o_dbg_state, IDLE);
        i_rst_n = 1'b1;
        tick();
        check_idle("post_rst");

        // both requesting continuously from a fresh streak
        exp_q = '{32'd1, 32'd1, 32'd0, 32'd1, 32'd1, 32'd0};
        grant_order(6);
        drain();

        // fetch only, one-cycle memory latency
        mem[32'h100] = 32'h0050_0093;
        new_if(32'h100);
        run_txn(1, obs);
        // store with partial byte mask
        new_ls(32'h2000, 1'b1, 32'hDEAD_BEEF, 4'h3);
        run_txn(1, obs);
        // memory never answers
        new_ls(32'h3000, 1'b0, 32'h0, 4'hF);
        run_txn(TO + 2, obs);
        // ack on the same edge the counter expires
        new_if(32'h100);
        run_txn(TO, obs);
        new_ls(32'h2000, 1'b0, 32'h0, 4'hF);
        run_txn(TO, obs);

        // randomized traffic
        for (int t = 0; t < 150; t++) begin
            if (!if_pend && $urandom_range(0, 1) == 1) rand_if();
            if (!ls_pend && $urandom_range(0, 1) == 1) rand_ls();
            if (!if_pend && !ls_pend) begin
                i_mem_ack = 1'($urandom_range(0, 1));
                tick();
                check_idle("idle_gap");
                if ($urandom_range(0, 1) == 1) rand_if(); else rand_ls();
            end
            run_txn($urandom_range(1, 6), obs);
        end
        drain();

        // reset while an LS grant has pushed the streak to its cap
        new_if(32'h1004);
        new_ls(32'h1008, 1'b0, 32'h0, 4'hF);
        run_txn(1, obs);
        rand_ls();
        i_mem_ack = 1'b0;
        tick();
        check("rst_pre_mem_req", o_mem_req, 1);
        #2 i_rst_n = 1'b0;
        #1;
        check("rst_async_mem_req", o_mem_req, 0);
        check("rst_async_busy", o_busy, 0);
        check("rst_async_acks", {o_if_ack, o_ls_ack}, 0);
        @(negedge clk);
        i_rst_n = 1'b1;
        streak  = 0;
        exp_q = '{32'd1, 32'd1, 32'd0};
        grant_order(3);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: got no end of test expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port unified memory of the rv32i core between the instruction-fetch path and the load/store path. Each requester uses a hold-until-ack request/acknowledge handshake. The block grants one requester, drives the memory port from registered copies of that requester's payload, and returns the response or a timeout error. It sits between the fetch/LSU stages and the memory, and its `o_busy` output feeds pipeline stall logic.

## Interface
- `TIMEOUT`, 255: BUSY cycles without `i_mem_ack` before the transaction is aborted (1..65535).
- `MAX_LS_STREAK`, 2: consecutive load/store grants allowed while a fetch is pending (≥1).
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_if_req` in 1 / `i_if_addr` in 32: fetch request and word address. Held stable until `o_if_ack`.
- `o_if_ack` out 1 / `o_if_err` out 1 / `o_if_rdata` out 32: fetch response, valid only while ack is high.
- `i_ls_req` in 1 / `i_ls_addr` in 32 / `i_ls_wren` in 1 / `i_ls_wdata` in 32 / `i_ls_bmask` in 4: load/store request. Held stable until `o_ls_ack`.
- `o_ls_ack` out 1 / `o_ls_err` out 1 / `o_ls_rdata` out 32: load/store response.
- `o_mem_req` out 1 / `o_mem_addr` out 32 / `o_mem_wren` out 1 / `o_mem_wdata` out 32 / `o_mem_bmask` out 4: memory port, all registered.
- `i_mem_ack` in 1 / `i_mem_rdata` in 32: memory completion pulse and read data.
- `o_busy` out 1: high in any state other than IDLE.

## Operation
States: IDLE, BUSY, RESP.
- **IDLE**
  - If neither requester is asserting a request, stay in IDLE.
  - If exactly one requests, grant it.
  - If both request, grant LS unless `ls_streak == MAX_LS_STREAK`; in that case grant IF.
  - On grant: latch address/wren/wdata/bmask (fetch forces wren=0, bmask=4'hF), latch the source, set `o_mem_req`, clear the timeout counter, and go to BUSY.
- **ls_streak**
  - Increments (saturating at MAX_LS_STREAK) on each LS grant made while `i_if_req` is high.
  - Clears on every IF grant and on any LS grant made with `i_if_req` low.
- **BUSY**
  - `o_mem_req` stays high and the payload stays frozen.
  - On `i_mem_ack`: capture `i_mem_rdata` into the granted source's rdata register, raise that source's ack with err=0, drop `o_mem_req`, and go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT, drop `o_mem_req`, raise ack with err=1 and rdata=0, and go to RESP.
  - `i_mem_ack` arriving on the same edge as timeout wins: the transaction completes normally.
- **RESP**
  - The ack/err of the granted source is high for exactly one cycle, then IDLE.
  - Requests are not sampled in RESP.
- Writes return rdata=0.
- `i_mem_ack` seen in IDLE or RESP is ignored.
- The ungranted requester's ack/err/rdata stay 0.

## Timing
- Reset values: all outputs 0, state IDLE, ls_streak 0, counter 0. Reset asserted mid-transaction drops `o_mem_req` and any ack immediately (asynchronously); the memory must tolerate the abandoned access.
- **Request latency:** request sampled high at edge E → `o_mem_req` high from E.
- **Response latency:** `i_mem_ack` sampled at edge E+k (k≥1) → requester ack high during cycle E+k..E+k+1.
- **Best case:** requester ack visible 2 cycles after grant; back-to-back transactions every 3 cycles.
- **Timeout:** counter reaches TIMEOUT after TIMEOUT BUSY cycles → error ack the next cycle.
- **Requester obligation:** a requester sampling ack at an edge must update or deassert its request before the next edge (the IDLE sample).

## Structure
- Shared package `rv32i_pkg`:
  - `arb_state_t` enum {IDLE, BUSY, RESP}
  - `arb_src_t` enum {SRC_IF, SRC_LS}
  - `MEM_AW`/`MEM_DW` = 32
- One sub-module is natural: `arb_timeout_cnt`, with clear, enable and `$clog2(TIMEOUT+1)`-bit compare. It outputs `expired`.
- Everything else lives in one always_ff/always_comb pair.

## Test plan
- Fetch only, addr 0x100, mem ack 1 cycle after `o_mem_req` with rdata 0x00500093 → `o_if_ack` one cycle, `o_if_rdata` 0x00500093, `o_mem_wren`=0, `o_mem_bmask`=F.
- Store addr 0x2000, wdata 0xDEADBEEF, bmask 0x3 → memory port shows exactly these values; `o_ls_ack` with rdata 0.
- Both requesting continuously, MAX_LS_STREAK=2 → grant order LS, LS, IF, LS, LS, IF.
- TIMEOUT=4, memory never acks → `o_mem_req` high exactly 4 cycles, then `o_ls_err`=1 with ack for one cycle, then IDLE.
- `i_mem_ack` on the same edge as timeout expiry → err=0, data returned.
- `i_rst_n` low while in BUSY → `o_mem_req`/`o_busy` 0 immediately. After release, a pending request is granted normally and ls_streak restarts from 0.
